// File: rtl/flash_arbiter.sv
// flash_arbiter: grants icache/dcache miss reads onto the single SPI flash read port,
// sequences each read with abort and timeout. Optional FLASH_ARB_LASTWORD_EN adds a last-word buffer.
module flash_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        ic_req,
   input  logic [19:0] ic_addr,
   output logic        ic_valid,
   input  logic        dc_req,
   input  logic [19:0] dc_addr,
   output logic        dc_valid,
   output logic [31:0] rd_data,
   output logic        rd_err,
   output logic        fl_req,
   output logic [19:0] fl_addr,
   input  logic        fl_ready,
   input  logic [31:0] fl_data,
   output logic [1:0]  grant
);

   localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [TW-1:0] TIMER_LIM  = TW'(TIMEOUT);

   // Grant encoding mirrors the flash controller's mode select.
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_DC   = 2'b01;
   localparam logic [1:0] GNT_IC   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            fl_req_q, fl_req_d;
   logic [19:0]     fl_addr_q, fl_addr_d;
   logic [1:0]      grant_q, grant_d;
   logic            ic_valid_q, ic_valid_d;
   logic            dc_valid_q, dc_valid_d;
   logic [31:0]     rd_data_q, rd_data_d;
   logic            rd_err_q, rd_err_d;

   logic            pick_ic;
   logic [19:0]     sel_addr;
   logic            granted_req;
   logic            timed_out;
   logic            lw_hit;
   logic [31:0]     lw_rdata;

   assign pick_ic     = ic_req && (!dc_req || (starve_q == STARVE_LIM));
   assign sel_addr    = pick_ic ? ic_addr : dc_addr;
   assign granted_req = (grant_q == GNT_IC) ? ic_req : dc_req;
   assign timed_out   = (timer_q == TIMER_LIM);

`ifdef FLASH_ARB_LASTWORD_EN
   logic        lw_valid_q, lw_valid_d;
   logic [19:0] lw_addr_q, lw_addr_d;
   logic [31:0] lw_data_q, lw_data_d;

   always_comb begin
      lw_valid_d = lw_valid_q;
      lw_addr_d  = lw_addr_q;
      lw_data_d  = lw_data_q;
      if (state_q == ST_WAIT && granted_req) begin
         if (fl_ready) begin
            lw_valid_d = 1'b1;
            lw_addr_d  = fl_addr_q;
            lw_data_d  = fl_data;
         end else if (timed_out) begin
            lw_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: the buffer is a plain register, so reset its address and data too, not just valid.
      if (!resetn) begin
         lw_valid_q <= 1'b0;
         lw_addr_q  <= '0;
         lw_data_q  <= '0;
      end else begin
         lw_valid_q <= lw_valid_d;
         lw_addr_q  <= lw_addr_d;
         lw_data_q  <= lw_data_d;
      end
   end

   assign lw_hit   = lw_valid_q && (lw_addr_q == sel_addr);
   assign lw_rdata = lw_data_q;
`else
   assign lw_hit   = 1'b0;
   assign lw_rdata = '0;
`endif

   always_comb begin
      // NOTE: every _d takes its held value first, so no path through the case infers a latch.
      state_d    = state_q;
      starve_d   = starve_q;
      timer_d    = timer_q;
      fl_req_d   = fl_req_q;
      fl_addr_d  = fl_addr_q;
      grant_d    = grant_q;
      ic_valid_d = 1'b0;
      dc_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (ic_req || dc_req) begin
               grant_d   = pick_ic ? GNT_IC : GNT_DC;
               fl_addr_d = sel_addr;
               timer_d   = '0;
               if (pick_ic || !ic_req) begin
                  starve_d = '0;
               end else if (starve_q != STARVE_LIM) begin
                  starve_d = starve_q + 1'b1;
               end
               if (lw_hit) begin
                  state_d    = ST_RESP;
                  rd_data_d  = lw_rdata;
                  rd_err_d   = 1'b0;
                  ic_valid_d = pick_ic;
                  dc_valid_d = !pick_ic;
               end else begin
                  state_d  = ST_WAIT;
                  fl_req_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            timer_d = timer_q + 1'b1;
            // Abort outranks a same-cycle fl_ready; that data is dropped.
            if (!granted_req) begin
               state_d  = ST_IDLE;
               fl_req_d = 1'b0;
               grant_d  = GNT_NONE;
            end else if (fl_ready || timed_out) begin
               state_d    = ST_RESP;
               fl_req_d   = 1'b0;
               rd_data_d  = fl_ready ? fl_data : '0;
               rd_err_d   = !fl_ready;
               ic_valid_d = (grant_q == GNT_IC);
               dc_valid_d = (grant_q == GNT_DC);
            end
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            grant_d  = GNT_NONE;
            rd_err_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      if (!resetn) begin
         state_q    <= ST_IDLE;
         starve_q   <= '0;
         timer_q    <= '0;
         fl_req_q   <= 1'b0;
         fl_addr_q  <= '0;
         grant_q    <= GNT_NONE;
         ic_valid_q <= 1'b0;
         dc_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         timer_q    <= timer_d;
         fl_req_q   <= fl_req_d;
         fl_addr_q  <= fl_addr_d;
         grant_q    <= grant_d;
         ic_valid_q <= ic_valid_d;
         dc_valid_q <= dc_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign fl_req   = fl_req_q;
   assign fl_addr  = fl_addr_q;
   assign grant    = grant_q;
   assign ic_valid = ic_valid_q;
   assign dc_valid = dc_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: stimulus pushes expected responses, a negedge monitor checks strobes.
module tb_flash_arbiter;

   logic        CLK = 1'b0;
   logic        resetn = 1'b0;
   logic        ic_req = 1'b0;
   logic [19:0] ic_addr = '0;
   logic        ic_valid;
   logic        dc_req = 1'b0;
   logic [19:0] dc_addr = '0;
   logic        dc_valid;
   logic [31:0] rd_data;
   logic        rd_err;
   logic        fl_req;
   logic [19:0] fl_addr;
   logic        fl_ready = 1'b0;
   logic [31:0] fl_data = '0;
   logic [1:0]  grant;

   typedef struct packed {
      logic        is_ic;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   flash_arbiter #(.STARVE_MAX(4), .TIMEOUT(1023)) dut (
      .CLK(CLK), .resetn(resetn),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid),
      .dc_req(dc_req), .dc_addr(dc_addr), .dc_valid(dc_valid),
      .rd_data(rd_data), .rd_err(rd_err),
      .fl_req(fl_req), .fl_addr(fl_addr),
      .fl_ready(fl_ready), .fl_data(fl_data),
      .grant(grant)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Pulse fl_ready for one WAIT cycle; the strobe must appear in the very next cycle.
   task automatic pulse_ready(input logic [31:0] d, input logic is_ic);
      exp_t e;
      fl_ready = 1'b1;
      fl_data  = d;
      e.is_ic  = is_ic;
      e.data   = d;
      e.err    = 1'b0;
      sb_q.push_back(e);
      tick();
      fl_ready = 1'b0;
      fl_data  = 32'hA5A5_5A5A;
      check("strobe_latency", 64'({ic_valid, dc_valid}), is_ic ? 64'h2 : 64'h1);
      check("fl_req_low_in_resp", 64'(fl_req), 64'h0);
   endtask

   task automatic wait_fl_req(input string name);
      int n = 0;
      while (fl_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(name, 64'(fl_req), 64'h1);
   endtask

   // Monitor: pop and compare whenever a strobe is presented.
   always @(negedge CLK) begin
      if (resetn && (ic_valid || dc_valid)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", 64'({ic_valid, dc_valid}), 64'h0);
         end else begin
            mon_e = sb_q.pop_front();
            check("strobe_target", 64'({ic_valid, dc_valid}), mon_e.is_ic ? 64'h2 : 64'h1);
            check("rd_data", 64'(rd_data), 64'(mon_e.data));
            check("rd_err", 64'(rd_err), 64'(mon_e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  exp_gnt [6];
      logic [19:0] next_dc;
      exp_t        e;
      exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

      // Reset state.
      repeat (3) tick();
      check("rst_fl_req", 64'(fl_req), 64'h0);
      check("rst_fl_addr", 64'(fl_addr), 64'h0);
      check("rst_grant", 64'(grant), 64'h0);
      check("rst_strobes", 64'({ic_valid, dc_valid}), 64'h0);
      check("rst_rd_data", 64'(rd_data), 64'h0);
      check("rst_rd_err", 64'(rd_err), 64'h0);

      // Reset applied mid-WAIT, then the same dcache request is accepted again.
      resetn  = 1'b1;
      dc_req  = 1'b1;
      dc_addr = 20'h12345;
      tick();
      check("pre_rst_fl_req", 64'(fl_req), 64'h1);
      check("pre_rst_grant", 64'(grant), 64'h1);
      resetn = 1'b0;
      tick();
      check("midrst_fl_req", 64'(fl_req), 64'h0);
      check("midrst_grant", 64'(grant), 64'h0);
      check("midrst_strobes", 64'({ic_valid, dc_valid}), 64'h0);
      resetn = 1'b1;
      tick();
      check("post_rst_fl_req", 64'(fl_req), 64'h1);
      check("post_rst_fl_addr", 64'(fl_addr), 64'h12345);
      check("post_rst_grant", 64'(grant), 64'h1);
      tick();
      pulse_ready(32'h1111_2222, 1'b0);
      dc_req = 1'b0;
      tick();
      check("strobe_one_cycle", 64'({ic_valid, dc_valid}), 64'h0);

      // Single icache read, controller answers on its 10th cycle.
      ic_req  = 1'b1;
      ic_addr = 20'h00100;
      tick();
      check("ic_fl_req", 64'(fl_req), 64'h1);
      check("ic_fl_addr", 64'(fl_addr), 64'h00100);
      check("ic_grant", 64'(grant), 64'h2);
      repeat (9) tick();
      pulse_ready(32'hDEAD_BEEF, 1'b1);
      ic_req = 1'b0;
      tick();
      check("ic_strobe_one_cycle", 64'({ic_valid, dc_valid}), 64'h0);
      check("ic_grant_released", 64'(grant), 64'h0);

      // Both requesting continuously: four dcache grants, then icache, then dcache.
      next_dc = 20'h00B00;
      ic_addr = 20'h00AAA;
      dc_addr = next_dc;
      ic_req  = 1'b1;
      dc_req  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_fl_req("starve_fl_req_rise");
         check("starve_grant", 64'(grant), 64'(exp_gnt[k]));
         check("starve_fl_addr", 64'(fl_addr), exp_gnt[k] == 2'b10 ? 64'h00AAA : 64'(next_dc));
         tick();
         pulse_ready(32'hC0DE_0000 + 32'(k), exp_gnt[k] == 2'b10);
         if (exp_gnt[k] == 2'b01) begin
            next_dc = next_dc + 20'h1;
            dc_addr = next_dc;
         end
         if (k == 5) begin
            ic_req = 1'b0;
            dc_req = 1'b0;
         end
      end
      tick();

      // dcache withdraws in its 3rd WAIT cycle while fl_ready arrives the same cycle.
      ic_req  = 1'b1;
      ic_addr = 20'h00EEE;
      dc_req  = 1'b1;
      dc_addr = 20'h00DDD;
      tick();
      check("abort_grant_dc", 64'(grant), 64'h1);
      check("abort_fl_addr_dc", 64'(fl_addr), 64'h00DDD);
      repeat (2) tick();
      dc_req   = 1'b0;
      fl_ready = 1'b1;
      fl_data  = 32'hBAD0_BAD0;
      tick();
      fl_ready = 1'b0;
      check("abort_fl_req_low", 64'(fl_req), 64'h0);
      check("abort_grant_none", 64'(grant), 64'h0);
      check("abort_no_strobe", 64'({ic_valid, dc_valid}), 64'h0);
      tick();
      check("abort_ic_fl_req", 64'(fl_req), 64'h1);
      check("abort_ic_grant", 64'(grant), 64'h2);
      check("abort_ic_fl_addr", 64'(fl_addr), 64'h00EEE);
      tick();
      pulse_ready(32'h0EEE_0EEE, 1'b1);
      ic_req = 1'b0;
      tick();

      // fl_ready while idle is ignored.
      fl_ready = 1'b1;
      tick();
      fl_ready = 1'b0;
      check("idle_ready_fl_req", 64'(fl_req), 64'h0);
      tick();
      check("idle_ready_no_strobe", 64'({ic_valid, dc_valid}), 64'h0);

`ifdef FLASH_ARB_LASTWORD_EN
      // Last-word buffer: second read of the same word bypasses the flash.
      ic_req  = 1'b1;
      ic_addr = 20'h00040;
      tick();
      check("lw_first_fl_req", 64'(fl_req), 64'h1);
      tick();
      pulse_ready(32'h4040_4040, 1'b1);
      ic_req = 1'b0;
      tick();
      ic_req  = 1'b1;
      e.is_ic = 1'b1;
      e.data  = 32'h4040_4040;
      e.err   = 1'b0;
      sb_q.push_back(e);
      tick();
      check("lw_hit_strobe", 64'(ic_valid), 64'h1);
      check("lw_hit_fl_req", 64'(fl_req), 64'h0);
      ic_req = 1'b0;
      tick();
`endif

      // Timeout: no fl_ready, error strobe TIMEOUT+1 cycles after fl_req rises.
      dc_req  = 1'b1;
      dc_addr = 20'h00F00;
      fl_data = 32'hFFFF_FFFF;
      tick();
      check("to_fl_req_rise", 64'(fl_req), 64'h1);
      repeat (1023) tick();
      check("to_still_waiting", 64'(fl_req), 64'h1);
      check("to_not_early", 64'(dc_valid), 64'h0);
      e.is_ic = 1'b0;
      e.data  = 32'h0;
      e.err   = 1'b1;
      sb_q.push_back(e);
      tick();
      check("to_strobe", 64'(dc_valid), 64'h1);
      check("to_fl_req_low", 64'(fl_req), 64'h0);
      dc_req = 1'b0;
      tick();
      check("to_strobe_one_cycle", 64'({ic_valid, dc_valid}), 64'h0);

`ifdef FLASH_ARB_LASTWORD_EN
      // After a timeout the buffered word is gone and the read goes to flash.
      ic_req  = 1'b1;
      ic_addr = 20'h00040;
      tick();
      check("lw_cleared_fl_req", 64'(fl_req), 64'h1);
      tick();
      pulse_ready(32'h4141_4141, 1'b1);
      ic_req = 1'b0;
      tick();
`endif

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
